// File: rtl/maple_tx.sv
// -----------------------------------------------------------------------------
// maple_tx
// Maple bus frame transmitter. Each frame is sent as a sequence of whole bus
// phases, each PHASE_CLKS clk cycles long: a lead phase, the start pattern,
// two phases per payload bit, and the end pattern. Payload bytes arrive
// through a one-byte holding register using a valid/ready handshake.
//
// Optional feature: define MAPLE_TX_CRC_EN to append an XOR checksum byte
// after the payload.
//
// Parameters:
//   PHASE_CLKS  clk cycles per bus phase (2..255)
// Ports:
//   clk       system clock; all state changes on its rising edge
//   rst       synchronous, active-high reset
//   start     single-cycle request to begin a frame (ignored unless idle)
//   tx_data   payload byte, sent MSB first
//   tx_last   marks tx_data as the final payload byte
//   tx_valid  tx_data/tx_last are valid
//   tx_ready  block accepts a byte this cycle
//   out_p1    registered drive level for pin 1
//   out_p5    registered drive level for pin 5
//   oe        output enable for the selected Maple port
//   busy      frame in progress
//   done      one-cycle pulse when a frame completes
//   underrun  qualifies done: the payload ran dry before tx_last was sent
// -----------------------------------------------------------------------------
module maple_tx #(
    parameter int PHASE_CLKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       out_p1,
    output logic       out_p5,
    output logic       oe,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam logic [7:0] PH_RELOAD = 8'(PHASE_CLKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_START,
        ST_DATA,
`ifdef MAPLE_TX_CRC_EN
        ST_CRC,
`endif
        ST_END
    } state_t;

    state_t     state;
    logic [7:0] phase_cnt;
    logic [3:0] step;
    logic [7:0] shift;
    logic       byte_last;
    logic [7:0] hold_data;
    logic       hold_full;
    logic       hold_last;
    logic       last_acc;
    logic       under_flag;
`ifdef MAPLE_TX_CRC_EN
    logic [7:0] csum;
`endif

    // Index of the final phase within each multi-phase state.
    function automatic logic [3:0] final_step(input state_t st);
        case (st)
            ST_START: final_step = 4'd9;
            ST_DATA:  final_step = 4'd15;
`ifdef MAPLE_TX_CRC_EN
            ST_CRC:   final_step = 4'd15;
`endif
            ST_END:   final_step = 4'd5;
            default:  final_step = 4'd0;
        endcase
    endfunction

    // Pin levels {p1, p5} for a given state and phase step. In a bit slot,
    // step[3:1] is the bit (MSB first), step[0] selects the S0/S1 half, and
    // step[1] is the global bit parity: every byte holds eight bits, so a
    // byte always starts on an even global index.
    function automatic logic [1:0] drive(input state_t st, input logic [3:0] stp,
                                         input logic [7:0] byt);
        logic b;
        logic clk_lv;
        b      = byt[3'd7 - stp[3:1]];
        clk_lv = ~stp[0];
        case (st)
            ST_START: begin
                if (stp == 4'd0)
                    drive = 2'b01;
                else if (stp == 4'd9)
                    drive = 2'b11;
                else
                    drive = {1'b0, ~stp[0]};
            end
            ST_DATA:  drive = stp[1] ? {b, clk_lv} : {clk_lv, b};
`ifdef MAPLE_TX_CRC_EN
            ST_CRC:   drive = stp[1] ? {b, clk_lv} : {clk_lv, b};
`endif
            ST_END:   drive = (stp == 4'd5) ? 2'b11 : {~stp[0], 1'b0};
            default:  drive = 2'b11;
        endcase
    endfunction

    // The holding register only accepts while a frame runs and before the
    // tx_last byte has been taken; reset masks it immediately.
    assign tx_ready = busy & ~hold_full & ~last_acc & ~rst;

    // Frame sequencer. Pin levels are registered alongside the state so that
    // each phase's levels appear on the same edge the phase begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            phase_cnt  <= '0;
            step       <= '0;
            shift      <= '0;
            byte_last  <= 1'b0;
            hold_data  <= '0;
            hold_full  <= 1'b0;
            hold_last  <= 1'b0;
            last_acc   <= 1'b0;
            under_flag <= 1'b0;
            out_p1     <= 1'b1;
            out_p5     <= 1'b1;
            oe         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
`ifdef MAPLE_TX_CRC_EN
            csum       <= '0;
`endif
        end else begin
            done     <= 1'b0;
            underrun <= 1'b0;

            if (tx_valid && tx_ready) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
                hold_last <= tx_last;
                if (tx_last)
                    last_acc <= 1'b1;
`ifdef MAPLE_TX_CRC_EN
                csum <= csum ^ tx_data;
`endif
            end

            if (state == ST_IDLE) begin
                if (start) begin
                    state      <= ST_LEAD;
                    busy       <= 1'b1;
                    oe         <= 1'b1;
                    phase_cnt  <= PH_RELOAD;
                    step       <= '0;
                    byte_last  <= 1'b0;
                    hold_full  <= 1'b0;
                    last_acc   <= 1'b0;
                    under_flag <= 1'b0;
                    out_p1     <= 1'b1;
                    out_p5     <= 1'b1;
`ifdef MAPLE_TX_CRC_EN
                    csum       <= '0;
`endif
                end
            end else if (phase_cnt != 8'd0) begin
                phase_cnt <= phase_cnt - 8'd1;
            end else begin
                phase_cnt <= PH_RELOAD;
                if (step != final_step(state)) begin
                    step <= step + 4'd1;
                    {out_p1, out_p5} <= drive(state, step + 4'd1, shift);
                end else begin
                    step <= '0;
                    case (state)
                        ST_LEAD: begin
                            state <= ST_START;
                            {out_p1, out_p5} <= drive(ST_START, 4'd0, shift);
                        end
                        // Byte boundary: either the payload is finished, the
                        // next byte is waiting, or the frame has underrun.
                        ST_START, ST_DATA: begin
                            if (state == ST_DATA && byte_last) begin
`ifdef MAPLE_TX_CRC_EN
                                state <= ST_CRC;
                                shift <= csum;
                                {out_p1, out_p5} <= drive(ST_CRC, 4'd0, csum);
`else
                                state <= ST_END;
                                {out_p1, out_p5} <= drive(ST_END, 4'd0, shift);
`endif
                            end else if (hold_full) begin
                                state     <= ST_DATA;
                                shift     <= hold_data;
                                byte_last <= hold_last;
                                hold_full <= 1'b0;
                                {out_p1, out_p5} <= drive(ST_DATA, 4'd0, hold_data);
                            end else begin
                                state      <= ST_END;
                                under_flag <= 1'b1;
                                {out_p1, out_p5} <= drive(ST_END, 4'd0, shift);
                            end
                        end
`ifdef MAPLE_TX_CRC_EN
                        ST_CRC: begin
                            state <= ST_END;
                            {out_p1, out_p5} <= drive(ST_END, 4'd0, shift);
                        end
`endif
                        ST_END: begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            oe       <= 1'b0;
                            done     <= 1'b1;
                            underrun <= under_flag;
                            out_p1   <= 1'b1;
                            out_p5   <= 1'b1;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule
